// File: rtl/vga_rect_blitter.sv
// vga_rect_blitter: streams an IMG_W x IMG_H rectangle, one pixel per clock,
// to a VGA adapter. Pixels come from a synchronous image ROM or a solid fill colour.
// Off-screen pixels are suppressed. busy and done report progress.
// Optional: define VGA_RECT_BLITTER_TRANSPARENT_EN to skip image pixels
// equal to TRANSPARENT_COLOR.
module vga_rect_blitter #(
    parameter                         RESOLUTION        = "160x120",
    parameter int                     COLOR_DEPTH       = 9,
    parameter int                     IMG_W             = 16,
    parameter int                     IMG_H             = 16,
    parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_COLOR = '0,
    localparam int XW = (RESOLUTION == "640x480") ? 10 :
                        (RESOLUTION == "320x240") ? 9 : 8,
    localparam int AW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   mode,
    input  logic [XW-1:0]          x0,
    input  logic [XW-2:0]          y0,
    input  logic [COLOR_DEPTH-1:0] fill_color,
    output logic [AW-1:0]          rom_addr,
    input  logic [COLOR_DEPTH-1:0] rom_data,
    output logic [XW-1:0]          VGA_X,
    output logic [XW-2:0]          VGA_Y,
    output logic [23:0]            VGA_COLOR,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int SCR_W = (XW == 10) ? 640 : (XW == 9) ? 320 : 160;
    localparam int SCR_H = (XW == 10) ? 480 : (XW == 9) ? 240 : 120;
    localparam int C     = COLOR_DEPTH / 3;
    localparam int CXW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int CYW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [CXW-1:0]         cx_q, cx_d;
    logic [CYW-1:0]         cy_q, cy_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [XW-1:0]          x0_q, x0_d;
    logic [XW-2:0]          y0_q, y0_d;
    logic                   mode_q, mode_d;
    logic [COLOR_DEPTH-1:0] fill_q, fill_d;

    // Pixel stage, aligned with the ROM read data.
    logic                   pix_valid_q;
    logic                   pix_on_q;
    logic [XW-1:0]          vga_x_q;
    logic [XW-2:0]          vga_y_q;

    logic [XW:0]            x_sum;
    logic [XW-1:0]          y_sum;
    logic                   on_screen;
    logic [COLOR_DEPTH-1:0] pix_color;
    logic                   skip;

    // Replicate a C-bit channel MSB-first until it fills 8 bits.
    function automatic logic [7:0] expand_ch(input logic [C-1:0] ch);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = ch[C-1-(i % C)];
        end
        return r;
    endfunction

    // FSM and scan counters: next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        addr_d  = addr_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    mode_d  = mode;
                    fill_d  = fill_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    addr_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                addr_d = addr_q + AW'(1);
                if (cx_q == CXW'(IMG_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == CYW'(IMG_H - 1)) begin
                        state_d = S_FLUSH;
                    end else begin
                        cy_d = cy_q + CYW'(1);
                    end
                end else begin
                    cx_d = cx_q + CXW'(1);
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Screen coordinates and clip test for the slot addressed this cycle.
    always_comb begin
        x_sum     = {1'b0, x0_q} + (XW+1)'(cx_q);
        y_sum     = {1'b0, y0_q} + XW'(cy_q);
        on_screen = (x_sum < (XW+1)'(SCR_W)) && (y_sum < XW'(SCR_H));
    end

    // State, counters, latched request and the one-deep pixel pipeline.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            addr_q      <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            mode_q      <= 1'b0;
            fill_q      <= '0;
            pix_valid_q <= 1'b0;
            pix_on_q    <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            addr_q      <= addr_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
            pix_valid_q <= (state_q == S_RUN);
            pix_on_q    <= on_screen;
            vga_x_q     <= x_sum[XW-1:0];
            vga_y_q     <= y_sum[XW-2:0];
        end
    end

`ifdef VGA_RECT_BLITTER_TRANSPARENT_EN
    assign skip = !mode_q && (rom_data == TRANSPARENT_COLOR);
`else
    logic unused_transparent;
    assign unused_transparent = ^TRANSPARENT_COLOR;
    assign skip = 1'b0;
`endif

    // The colour is gated by the valid bit so the outputs read 0 outside a pixel slot.
    assign pix_color = mode_q ? fill_q : rom_data;
    assign VGA_COLOR = pix_valid_q ? {expand_ch(pix_color[3*C-1:2*C]),
                                      expand_ch(pix_color[2*C-1:C]),
                                      expand_ch(pix_color[C-1:0])} : 24'd0;
    assign plot      = pix_valid_q && pix_on_q && !skip;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign rom_addr  = addr_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);

endmodule

// File: doc/vga_rect_blitter.md
Name: vga_rect_blitter

Overview:
- Sequential pixel source for the VGA adapter/DeSIM VGA path.
- Streams either an IMG_W x IMG_H image from a synchronous MIF-initialised ROM or a solid-colour rectangle to (x0,y0) on screen.
- Drives VGA_X/VGA_Y/VGA_COLOR/plot one pixel per clock, clips off-screen pixels, and reports busy/done.
- Successor to the fixed single-image demo: resolution, colour depth and image size are all parametrised, and it adds a fill mode.

Parameters:
- RESOLUTION, "160x120", one of "640x480", "320x240", "160x120".
- COLOR_DEPTH, 9, bits per pixel in the ROM and in fill_color; 9, 6 or 3 (COLOR_DEPTH/3 bits per channel).
- IMG_W, 16, rectangle/image width in pixels (>=1).
- IMG_H, 16, rectangle/image height in pixels (>=1).
- XW, derived: 10/9/8 for the three resolutions; Y width is XW-1.
- AW, derived: clog2(IMG_W*IMG_H), ROM address width.
- TRANSPARENT_COLOR, 0, key colour (COLOR_DEPTH bits); used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = draw image from ROM, 1 = solid fill.
- x0  in  XW  top-left X of the rectangle.
- y0  in  XW-1  top-left Y of the rectangle.
- fill_color  in  COLOR_DEPTH  colour used in fill mode.
- rom_addr  out  AW  ROM read address.
- rom_data  in  COLOR_DEPTH  ROM read data, valid 1 cycle after rom_addr.
- VGA_X  out  XW  pixel X.
- VGA_Y  out  XW-1  pixel Y.
- VGA_COLOR  out  24  pixel colour, expanded to 8 bits per channel.
- plot  out  1  write strobe for the current pixel.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel slot.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE.
- Reset is asynchronous, takes effect at any time, and aborts a draw in progress. No further plot is issued after reset deasserts until a new start.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: on start=1, latch x0, y0, mode and fill_color; clear the counters cx=cy=addr=0; go to RUN.
- RUN:
  - Each cycle presents rom_addr=addr.
  - Increment cx; at cx=IMG_W-1, wrap cx to 0 and increment cy.
  - addr increments linearly (row-major, addr = cy*IMG_W+cx); no multiplier is required.
  - After the slot with cx=IMG_W-1 and cy=IMG_H-1, go to FLUSH.
- FLUSH: one cycle that drains the ROM pipeline stage; then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy is 0 in IDLE and in DONE.
- Pipeline: the pixel for slot (cx,cy) appears on VGA_X/VGA_Y/VGA_COLOR/plot exactly 1 cycle after its rom_addr. Fill mode uses the same latency. First plot occurs 2 cycles after the start edge. Total time from start to done is IMG_W*IMG_H+2 cycles.
- Coordinates: VGA_X=x0+cx and VGA_Y=y0+cy, computed one bit wider than the port. If the sum is >= the screen width or height, that slot has plot=0 (clipped) and the coordinates are don't-care.
- Colour expansion: each channel of C=COLOR_DEPTH/3 bits is replicated MSB-first to fill 8 bits. Channel order is R,G,B from MSB.
- start while busy or in DONE: ignored; latched parameters are unchanged.
- mode, x0, y0 and fill_color are only sampled at acceptance; changes during RUN have no effect.

Optional Feature:
- Macro: VGA_RECT_BLITTER_TRANSPARENT_EN.
- Defined: in image mode, a ROM pixel equal to TRANSPARENT_COLOR produces plot=0 for that slot. Timing and done are unchanged. Fill mode is unaffected.
- Undefined: every on-screen slot plots. The TRANSPARENT_COLOR parameter is unused.

Test Plan:
- Basic draw: 160x120, IMG 4x4, ROM[i]=i, start with x0=10, y0=20, mode=0 → 16 plots, first at cycle start+2 with (10,20); last is (13,23) with colour from ROM[15]=9'h00F; done at start+18.
- Colour expansion: COLOR_DEPTH=9, fill_color=9'b101_000_111, mode=1, 2x2 at (0,0) → 4 plots with VGA_COLOR=24'hB600FF.
- Clipping: 160x120, 4x4 at (158,118) → only (158,118), (159,118), (158,119), (159,119) plot; 12 slots have plot=0; done still at start+18.
- Ignored start: pulse start again at start+5 with a different x0 → plot sequence unchanged; exactly one done pulse.
- Reset mid-draw: assert resetn=0 at start+7 → all outputs 0 immediately (asynchronous). After release, no plot and no done until a new start; a new start produces the full sequence.
- Transparency (macro defined, TRANSPARENT_COLOR=0): 4x4 with ROM[0]=0 → 15 plots; slot (x0,y0) skipped.
